// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: signal bundle between the IF-stage sequencer and the pipeline.
//   master (pipeline side) drives: load_use_hazard, jump_req, jump_target,
//     branch_req, branch_target, if_instr
//   slave (fetch_ctrl) drives: pc_en, pc_load, redirect_addr, if_id_en,
//     if_id_flush, id_ex_flush, halted
//   FETCH_PERF_CNT_EN adds stall_cnt and flush_cnt, driven by the slave.
interface fetch_ctrl_if #(parameter int WORD = 32);
    logic            load_use_hazard;
    logic            jump_req;
    logic [WORD-1:0] jump_target;
    logic            branch_req;
    logic [WORD-1:0] branch_target;
    logic [WORD-1:0] if_instr;
    logic            pc_en;
    logic            pc_load;
    logic [WORD-1:0] redirect_addr;
    logic            if_id_en;
    logic            if_id_flush;
    logic            id_ex_flush;
    logic            halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
    modport master(
        output load_use_hazard, jump_req, jump_target, branch_req, branch_target, if_instr,
        input  pc_en, pc_load, redirect_addr, if_id_en, if_id_flush, id_ex_flush, halted,
        input  stall_cnt, flush_cnt
    );
    modport slave(
        input  load_use_hazard, jump_req, jump_target, branch_req, branch_target, if_instr,
        output pc_en, pc_load, redirect_addr, if_id_en, if_id_flush, id_ex_flush, halted,
        output stall_cnt, flush_cnt
    );
`else
    modport master(
        output load_use_hazard, jump_req, jump_target, branch_req, branch_target, if_instr,
        input  pc_en, pc_load, redirect_addr, if_id_en, if_id_flush, id_ex_flush, halted
    );
    modport slave(
        input  load_use_hazard, jump_req, jump_target, branch_req, branch_target, if_instr,
        output pc_en, pc_load, redirect_addr, if_id_en, if_id_flush, id_ex_flush, halted
    );
`endif
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer -- redirect arbitration, load-use stalls, halt drain.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : fetch_ctrl_if.slave (hazard/jump/branch/instr in; PC and pipeline controls out)
//   FETCH_PERF_CNT_EN: when defined, drives bus.stall_cnt / bus.flush_cnt.
module fetch_ctrl #(
    parameter int              WORD         = 32,
    parameter int              DRAIN_CYCLES = 4,
    parameter logic [WORD-1:0] HALT_INSTR   = 32'hFFFF_FFFF
) (
    input logic         clk,
    input logic         rst,
    fetch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;
    state_t     state;
    logic [3:0] cnt;
    logic       live, run, br, lu, jp, hw, fetch;
    // Branch from EX outranks everything younger; in DRAIN it rescues a wrong-path halt.
    assign live  = !rst && (state == RUN || state == DRAIN);
    assign run   = !rst && state == RUN;
    assign br    = live && bus.branch_req;
    assign lu    = run && !bus.branch_req && bus.load_use_hazard;
    assign jp    = run && !bus.branch_req && !bus.load_use_hazard && bus.jump_req;
    assign hw    = run && !bus.branch_req && !bus.load_use_hazard && !bus.jump_req
                   && bus.if_instr == HALT_INSTR;
    assign fetch = run && !br && !lu && !jp && !hw;
    assign bus.pc_load       = br || jp;
    assign bus.pc_en         = br || jp || fetch;
    assign bus.redirect_addr = br ? bus.branch_target : jp ? bus.jump_target : '0;
    assign bus.if_id_flush   = rst || state != RUN || br || jp || hw;
    assign bus.if_id_en      = !rst && state != HALTED && !lu;
    assign bus.id_ex_flush   = rst || state == BOOT || state == HALTED || br || lu;
    assign bus.halted        = !rst && state == HALTED;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: if (hw) begin
                    state <= DRAIN;
                    cnt   <= 4'(DRAIN_CYCLES - 1);
                end
                DRAIN: if (bus.branch_req) begin
                    state <= RUN;
                    cnt   <= '0;
                end else if (cnt == '0) begin
                    state <= HALTED;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= HALTED;
            endcase
        end
    end
`ifdef FETCH_PERF_CNT_EN
    // No stall or redirect can occur in HALTED, so both counters freeze there.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stall_cnt <= '0;
            bus.flush_cnt <= '0;
        end else begin
            if (lu && bus.stall_cnt != '1) bus.stall_cnt <= bus.stall_cnt + 32'd1;
            if ((br || jp) && bus.flush_cnt != '1) bus.flush_cnt <= bus.flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
    localparam int          WORD  = 32;
    localparam int          DRAIN = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    fetch_ctrl_if #(.WORD(WORD)) bus();
    fetch_ctrl dut(.clk(clk), .rst(rst), .bus(bus));
    int n_checks = 0;
    int n_fail   = 0;
    // model: phase flags plus how many drain cycles have elapsed
    bit     m_boot, m_drain, m_halt;
    int     m_age;
    longint m_stall, m_flush;
    bit     f_rst, f_b, f_redir, f_stall, f_halt_fetch;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // Apply inputs in the low phase, compare every output to the model.
    task automatic drive(input bit r, input bit lu, input bit j, input logic [31:0] jt,
                         input bit b, input logic [31:0] bt, input logic [31:0] ins);
        bit e_en, e_ld, e_iden, e_iff, e_ief, e_h, running, redir_j;
        logic [31:0] e_ra;
        rst = r;
        bus.load_use_hazard = lu;
        bus.jump_req = j;
        bus.jump_target = jt;
        bus.branch_req = b;
        bus.branch_target = bt;
        bus.if_instr = ins;
        #1;
        running      = !r && !m_boot && !m_halt && !m_drain;
        f_rst        = r;
        f_b          = !r && !m_boot && !m_halt && b;
        f_stall      = running && !b && lu;
        redir_j      = running && !b && !lu && j;
        f_redir      = f_b || redir_j;
        f_halt_fetch = running && !b && !lu && !j && ins == HALT;
        e_h = 0; e_ra = 0; e_ld = 0;
        if (r) begin
            e_en = 0; e_iden = 0; e_iff = 1; e_ief = 1;
        end else if (m_halt) begin
            e_en = 0; e_iden = 0; e_iff = 1; e_ief = 1; e_h = 1;
        end else if (m_boot) begin
            e_en = 0; e_iden = 1; e_iff = 1; e_ief = 1;
        end else if (f_b) begin
            e_en = 1; e_ld = 1; e_ra = bt; e_iden = 1; e_iff = 1; e_ief = 1;
        end else if (m_drain) begin
            e_en = 0; e_iden = 1; e_iff = 1; e_ief = 0;
        end else if (f_stall) begin
            e_en = 0; e_iden = 0; e_iff = 0; e_ief = 1;
        end else if (redir_j) begin
            e_en = 1; e_ld = 1; e_ra = jt; e_iden = 1; e_iff = 1; e_ief = 0;
        end else if (f_halt_fetch) begin
            e_en = 0; e_iden = 1; e_iff = 1; e_ief = 0;
        end else begin
            e_en = 1; e_iden = 1; e_iff = 0; e_ief = 0;
        end
        check("pc_en", 32'(bus.pc_en), 32'(e_en));
        check("pc_load", 32'(bus.pc_load), 32'(e_ld));
        check("redirect_addr", bus.redirect_addr, e_ra);
        check("if_id_en", 32'(bus.if_id_en), 32'(e_iden));
        check("if_id_flush", 32'(bus.if_id_flush), 32'(e_iff));
        check("id_ex_flush", 32'(bus.id_ex_flush), 32'(e_ief));
        check("halted", 32'(bus.halted), 32'(e_h));
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", bus.stall_cnt, m_stall[31:0]);
        check("flush_cnt", bus.flush_cnt, m_flush[31:0]);
`endif
    endtask
    // Clock edge: advance the model using the flags of the last drive.
    task automatic tick();
        @(posedge clk);
        if (f_rst) begin
            m_boot = 1; m_drain = 0; m_halt = 0; m_age = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (f_stall && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (f_redir && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (m_boot) m_boot = 0;
            else if (m_drain) begin
                if (f_b) m_drain = 0;
                else if (m_age == DRAIN - 1) begin m_drain = 0; m_halt = 1; end
                else m_age++;
            end else if (f_halt_fetch) begin
                m_drain = 1; m_age = 0;
            end
        end
        @(negedge clk);
    endtask
    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, NOP);
        tick();
    endtask
    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0, 0, NOP);
            tick();
        end
    endtask
    initial begin
        longint fl0;
        m_boot = 1; m_drain = 0; m_halt = 0; m_age = 0; m_stall = 0; m_flush = 0;
        rst = 1;
        bus.load_use_hazard = 0; bus.jump_req = 0; bus.jump_target = 0;
        bus.branch_req = 0; bus.branch_target = 0; bus.if_instr = NOP;
        @(negedge clk);
        // 1: reset, boot, then sequential fetch
        do_reset();
        drive(0, 0, 0, 0, 0, 0, NOP);
        check("t1 boot pc_en", 32'(bus.pc_en), 0);
        check("t1 boot id_ex_flush", 32'(bus.id_ex_flush), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, NOP);
        check("t1 run pc_en", 32'(bus.pc_en), 1);
        check("t1 run pc_load", 32'(bus.pc_load), 0);
        tick();
        idle(); idle();
        // 2: jump
        drive(0, 0, 1, 32'h40, 0, 0, NOP);
        check("t2 redirect", bus.redirect_addr, 32'h40);
        check("t2 id_ex_flush", 32'(bus.id_ex_flush), 0);
        tick();
        // 3: branch beats jump and hazard
        drive(0, 1, 1, 32'h40, 1, 32'h80, NOP);
        check("t3 redirect", bus.redirect_addr, 32'h80);
        check("t3 id_ex_flush", 32'(bus.id_ex_flush), 1);
        tick();
        // 4: stall holds jump, jump taken next cycle
        drive(0, 1, 1, 32'h40, 0, 0, NOP);
        check("t4 stall pc_en", 32'(bus.pc_en), 0);
        check("t4 stall pc_load", 32'(bus.pc_load), 0);
        tick();
        drive(0, 0, 1, 32'h40, 0, 0, NOP);
        check("t4 jump pc_load", 32'(bus.pc_load), 1);
        tick();
        // 5: halt word, drain, halted sticky, reset clears
        drive(0, 0, 0, 0, 0, 0, HALT);
        check("t5 halt pc_en", 32'(bus.pc_en), 0);
        tick();
        for (int i = 0; i < DRAIN; i++) begin
            drive(0, 0, 0, 0, 0, 0, NOP);
            check("t5 drain halted", 32'(bus.halted), 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 32'h44, 1, 32'h88, NOP);
            check("t5 halted sticky", 32'(bus.halted), 1);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, NOP);
        check("t5 rst halted", 32'(bus.halted), 0);
        tick();
        do_reset();
        idle(); idle();
        // 6: branch during drain rescues the program
        drive(0, 0, 0, 0, 0, 0, HALT);
        tick();
        idle();
        fl0 = m_flush;
        drive(0, 0, 0, 0, 1, 32'h100, NOP);
        check("t6 redirect", bus.redirect_addr, 32'h100);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 0, 0, NOP);
            check("t6 no halt", 32'(bus.halted), 0);
            tick();
        end
`ifdef FETCH_PERF_CNT_EN
        drive(0, 0, 0, 0, 0, 0, NOP);
        check("t6 flush_cnt", bus.flush_cnt, 32'(fl0 + 1));
        tick();
`endif
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 7) == 0, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 19) == 0 ? HALT : $urandom);
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
